min_reduce_ctrl: RTL and testbench

MIN_REDUCE_CTRL -- requirements
Module: min_reduce_ctrl

---
 rtl/min_pkg.sv | 18 +
 rtl/gt_uint_nbit.sv | 34 +++
 rtl/min_reduce_ctrl.sv | 144 ++++++++++++++
 tb/tb_min_reduce_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/min_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// min_pkg : shared state type and default sizes for the min-reduce controller
// Revision: 1.0
// ----------------------------------------------------------------------------
package min_pkg;

  localparam int c_DEFAULT_WIDTH = 16;
  localparam int c_DEFAULT_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/gt_uint_nbit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gt_uint_nbit : unsigned A > B magnitude comparator, selectable structure
// Revision: 1.0
// ----------------------------------------------------------------------------
module gt_uint_nbit #(
  parameter int WIDTH     = 16,
  parameter int IMPL_TYPE = 0
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_gt
);

  generate
    if (IMPL_TYPE == 0) begin : g_behav
      assign o_gt = (i_a > i_b);
    end else begin : g_ripple
      logic w_gt;

      // LSB-to-MSB chain: a higher differing bit always overrides lower ones
      always_comb begin
        w_gt = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
          w_gt = (i_a[i] & ~i_b[i]) | (~(i_a[i] ^ i_b[i]) & w_gt);
        end
      end

      assign o_gt = w_gt;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/min_reduce_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// min_reduce_ctrl : streams a len-element frame, reports its minimum and index
// Revision: 1.0
// ----------------------------------------------------------------------------
module min_reduce_ctrl
  import min_pkg::*;
#(
  parameter int WIDTH     = c_DEFAULT_WIDTH,
  parameter int IMPL_TYPE = 0,
  parameter int CNT_W     = c_DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_index,
  input  logic             out_ready,
  output logic             busy
);

  localparam logic [WIDTH-1:0] c_ALL_ONES = '1;
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_len;
  logic [WIDTH-1:0] r_out_data;
  logic [CNT_W-1:0] r_out_index;

  logic w_accept;
  logic w_last;
  logic w_gt;

  gt_uint_nbit #(
    .WIDTH     (WIDTH),
    .IMPL_TYPE (IMPL_TYPE)
  ) u_gt (
    .i_a  (r_acc),
    .i_b  (in_data),
    .o_gt (w_gt)
  );

  assign w_accept = in_valid && (r_state == ACCUM);
  assign w_last   = (r_cnt == (r_len - c_CNT_ONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (w_accept && w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (r_state)
      IDLE:    busy      = 1'b0;
      ACCUM:   in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: busy      = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= c_ALL_ONES;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_len       <= '0;
      r_out_data  <= '0;
      r_out_index <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_len <= len;
            r_acc <= c_ALL_ONES;
            r_idx <= '0;
            r_cnt <= '0;
            if (len == '0) begin
              r_out_data  <= c_ALL_ONES;
              r_out_index <= '0;
            end
          end
        end
        ACCUM: begin
          if (w_accept) begin
            r_cnt <= r_cnt + c_CNT_ONE;
            if (w_gt) begin
              r_acc <= in_data;
              r_idx <= r_cnt;
            end
            // Publish the winner of this final beat directly, giving 1-cycle latency
            if (w_last) begin
              r_out_data  <= w_gt ? in_data : r_acc;
              r_out_index <= w_gt ? r_cnt : r_idx;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_index = r_out_index;

endmodule
`default_nettype wire

// File: tb/tb_min_reduce_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_min_reduce_ctrl : directed and randomized frames against a min/argmin model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_min_reduce_ctrl;

  localparam int WIDTH = 16;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_index;
  logic             out_ready;
  logic             busy;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] frame_q[$];
  logic [WIDTH-1:0] last_data;
  int               last_idx;

  min_reduce_ctrl #(
    .WIDTH     (WIDTH),
    .IMPL_TYPE (1),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_index (out_index),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one frame from IDLE using frame_q as the element list; returns at a negedge in IDLE.
  task automatic run_frame(input int n, input bit gaps, input int hold, input bit poke_start);
    logic [WIDTH-1:0] exp_min;
    int               exp_idx;
    int               sent;
    exp_min = '1;
    exp_idx = 0;
    foreach (frame_q[i]) begin
      if (frame_q[i] < exp_min) begin
        exp_min = frame_q[i];
        exp_idx = i;
      end
    end

    check_val("idle_busy", busy, 0);
    check_val("idle_in_ready", in_ready, 0);
    start = 1'b1;
    len   = n[CNT_W-1:0];
    @(negedge clk);
    start = 1'b0;
    len   = CNT_W'($urandom);

    sent = 0;
    while (sent < n) begin
      check_val("accum_in_ready", in_ready, 1);
      check_val("accum_out_valid", out_valid, 0);
      check_val("accum_busy", busy, 1);
      check_val("accum_hold_data", out_data, last_data);
      check_val("accum_hold_idx", out_index, last_idx);
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = in_valid ? frame_q[sent] : WIDTH'($urandom);
      if (poke_start) begin
        start = 1'($urandom_range(0, 1));
        len   = CNT_W'($urandom);
      end
      @(negedge clk);
      if (in_valid) sent++;
    end
    in_valid = 1'b0;
    start    = 1'b0;

    check_val("done_out_valid", out_valid, 1);
    check_val("done_out_data", out_data, exp_min);
    check_val("done_out_index", out_index, exp_idx);
    check_val("done_in_ready", in_ready, 0);
    check_val("done_busy", busy, 1);

    out_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'($urandom);
      start    = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_val("stall_out_valid", out_valid, 1);
      check_val("stall_out_data", out_data, exp_min);
      check_val("stall_out_index", out_index, exp_idx);
    end
    in_valid  = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_val("post_out_valid", out_valid, 0);
    check_val("post_busy", busy, 0);
    check_val("post_hold_data", out_data, exp_min);
    check_val("post_hold_idx", out_index, exp_idx);
    last_data = exp_min;
    last_idx  = exp_idx;
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    last_data = '0;
    last_idx  = 0;

    @(negedge clk);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_out_index", out_index, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic frame with a tie: earliest 0x0010 wins
    frame_q = '{16'h0050, 16'h0010, 16'h0030, 16'h0010};
    run_frame(4, 1'b0, 0, 1'b0);

    // Empty frame
    frame_q = {};
    run_frame(0, 1'b0, 2, 1'b0);

    // Gaps and a stalled consumer
    frame_q = '{16'h0005, 16'h0007, 16'h0002};
    run_frame(3, 1'b1, 5, 1'b0);

    // Abort mid-frame with reset
    start = 1'b1;
    len   = 8'd4;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_data = 16'h0001 + 16'(k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check_val("abort_in_ready", in_ready, 0);
    check_val("abort_out_valid", out_valid, 0);
    check_val("abort_busy", busy, 0);
    check_val("abort_out_data", out_data, 0);
    check_val("abort_out_index", out_index, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("abort_wait_valid", out_valid, 0);
      check_val("abort_wait_busy", busy, 0);
    end
    last_data = '0;
    last_idx  = 0;
    frame_q = '{16'h1234};
    run_frame(1, 1'b0, 1, 1'b0);

    // Maximum length, minimum near the end, start poked throughout
    frame_q = {};
    for (int k = 0; k < 255; k++) frame_q.push_back((k == 254) ? 16'h0000 : 16'hFFFF);
    run_frame(255, 1'b0, 0, 1'b1);

    // All-ones frame keeps index 0
    frame_q = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
    run_frame(3, 1'b1, 0, 1'b0);

    // Randomized frames; narrow value range forces ties
    for (int f = 0; f < 12; f++) begin
      n = $urandom_range(1, 24);
      frame_q = {};
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 1) == 0) frame_q.push_back(WIDTH'($urandom_range(0, 15)));
        else                           frame_q.push_back(WIDTH'($urandom));
      end
      run_frame(n, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
